// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Accepts a framed byte stream (16-bit word count, N big-endian 32-bit words, XOR checksum
// of the payload bytes) over a valid/ready handshake and writes each assembled word to the
// instruction memory at word-aligned byte addresses. cpu_enable is held low until a clean
// load completes.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   start       one-cycle load request (honoured in IDLE, DONE, ERR)
//   byte_in     stream data byte
//   byte_valid  byte_in valid this cycle
//   byte_ready  loader accepts a byte this cycle
//   imem_we     instruction-memory write strobe (one cycle per word)
//   imem_waddr  byte address of the word being written (multiple of 4)
//   imem_wdata  assembled instruction word
//   cpu_enable  pipeline enable, high only in DONE
//   busy        load in progress
//   done        load finished cleanly
//   error       header or checksum error
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    StIdle, StHdrHi, StHdrLo, StLoad, StWrite, StCksum, StDone, StErr
  } state_e;

  // One extra bit so a 16-bit header count can be compared without overflow.
  localparam logic [16:0]      DepthCnt = 17'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_hi_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] word_idx_q;
  logic [1:0]       byte_cnt_q;
  logic [7:0]       cksum_q;
  logic [31:0]      word_q;

  logic             xfer;
  logic [15:0]      hdr_count;
  logic [CNT_W-1:0] idx_next;

  assign xfer      = byte_valid & byte_ready;
  assign hdr_count = {cnt_hi_q, byte_in};
  assign idx_next  = word_idx_q + CntOne;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StHdrHi;
      end
      StHdrHi: begin
        if (xfer) state_d = StHdrLo;
      end
      StHdrLo: begin
        if (xfer) begin
          if (hdr_count == 16'd0 || {1'b0, hdr_count} > DepthCnt) state_d = StErr;
          else                                                    state_d = StLoad;
        end
      end
      StLoad: begin
        if (xfer && byte_cnt_q == 2'd3) state_d = StWrite;
      end
      StWrite: begin
        state_d = (idx_next == count_q) ? StCksum : StLoad;
      end
      StCksum: begin
        if (xfer) state_d = (byte_in == cksum_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: pure decodes of registered state, no path from byte_valid/byte_in.
  always_comb begin
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    cpu_enable = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state_q)
      StHdrHi, StHdrLo, StLoad, StCksum: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      StWrite: begin
        imem_we = 1'b1;
        busy    = 1'b1;
      end
      StDone: begin
        cpu_enable = 1'b1;
        done       = 1'b1;
      end
      StErr:   error = 1'b1;
      default: ;
    endcase
  end

  assign imem_waddr = 32'(word_idx_q) << 2;
  assign imem_wdata = word_q;

  // Datapath: header capture, word assembly, checksum, word index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_hi_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      cksum_q    <= '0;
      word_q     <= '0;
    end else begin
      case (state_q)
        StIdle, StDone, StErr: begin
          if (start) begin
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            cksum_q    <= '0;
          end
        end
        StHdrHi: begin
          if (xfer) cnt_hi_q <= byte_in;
        end
        StHdrLo: begin
          if (xfer) count_q <= CNT_W'(hdr_count);
        end
        StLoad: begin
          if (xfer) begin
            word_q     <= {word_q[23:0], byte_in};
            cksum_q    <= cksum_q ^ byte_in;
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        StWrite: begin
          word_idx_q <= idx_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;

  // Observed writes and transfers, gathered at each rising edge
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          xfers = 0;
  int          ready_viol = 0;

  // Reference frame contents (words in order)
  logic [31:0] exp_words[$];

  imem_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
      if (byte_ready) ready_viol++;
    end
    if (byte_valid && byte_ready) xfers++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after start was seen.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ready_latency", 32'(byte_ready), 32'd1);
  endtask

  // Present one byte and hold it until accepted. Called and returns at a falling edge.
  task automatic push(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        @(negedge clk);
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $error("FAIL push_timeout: observed byte_ready 0 expected 1");
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  // Sends the frame held in exp_words; ck_xor != 0 corrupts the checksum.
  task automatic run_frame(input string tag, input bit gaps, input logic [7:0] ck_xor);
    int          nw;
    int          base_w;
    int          base_x;
    logic [15:0] n16;
    logic [7:0]  ck;
    logic [31:0] w;
    bit          good;
    nw     = exp_words.size();
    n16    = 16'(nw);
    base_w = wr_addr.size();
    base_x = xfers;
    ck     = 8'h00;
    foreach (exp_words[i]) begin
      w  = exp_words[i];
      ck = ck ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    good = (ck_xor == 8'h00);
    do_start();
    push(n16[15:8], gaps);
    push(n16[7:0], gaps);
    foreach (exp_words[i]) begin
      w = exp_words[i];
      for (int b = 3; b >= 0; b--) push(w[8*b +: 8], gaps);
    end
    push(ck ^ ck_xor, gaps);
    check({tag, "_done"}, 32'(done), 32'(good));
    check({tag, "_error"}, 32'(error), 32'(!good));
    check({tag, "_cpu_enable"}, 32'(cpu_enable), 32'(good));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_nwrites"}, 32'(wr_addr.size() - base_w), 32'(nw));
    for (int i = 0; i < nw && base_w + i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, wr_addr[base_w + i], 32'(i * 4));
      check({tag, "_data"}, wr_data[base_w + i], exp_words[i]);
    end
    check({tag, "_xfers"}, 32'(xfers - base_x), 32'(2 + 4 * nw + 1));
    check({tag, "_ready_in_write"}, 32'(ready_viol), 32'd0);
  endtask

  task automatic bad_header(input string tag, input logic [15:0] cnt);
    int base_w;
    base_w = wr_addr.size();
    do_start();
    push(cnt[15:8], 1'b0);
    push(cnt[7:0], 1'b0);
    check({tag, "_error"}, 32'(error), 32'd1);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_cpu_enable"}, 32'(cpu_enable), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_no_writes"}, 32'(wr_addr.size() - base_w), 32'd0);
    check({tag, "_still_err"}, 32'(error), 32'd1);
  endtask

  initial begin
    int base_w;

    // Reset state
    #1;
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_waddr", imem_waddr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_flags", {28'd0, cpu_enable, busy, done, error}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(byte_ready), 32'd0);

    // Clean 2-word load from the directed frame
    exp_words = '{32'h2001_0005, 32'h0000_0000};
    run_frame("clean", 1'b0, 8'h00);

    // Header errors
    bad_header("zero_count", 16'h0000);
    bad_header("overlength", 16'(DEPTH + 1));

    // Full-depth load with random contents
    exp_words.delete();
    for (int i = 0; i < DEPTH; i++) exp_words.push_back($urandom);
    run_frame("full", 1'b0, 8'h00);
    check("full_last_addr", wr_addr[wr_addr.size() - 1], 32'h0000_00FC);

    // Bad checksum (0x25 instead of 0x24), then recovery with a correct frame
    exp_words = '{32'h2001_0005, 32'h0000_0000};
    run_frame("bad_ck", 1'b0, 8'h01);
    run_frame("recover", 1'b0, 8'h00);

    // Clean frame with random gaps, then random frames with gaps and random corruption
    run_frame("gaps_clean", 1'b1, 8'h00);
    for (int t = 0; t < 6; t++) begin
      exp_words.delete();
      repeat ($urandom_range(1, 8)) exp_words.push_back($urandom);
      run_frame("rand", 1'b1, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
    end

    // Reset mid-load after 3 payload bytes; start while busy must be ignored
    base_w = wr_addr.size();
    do_start();
    push(8'h00, 1'b0);
    push(8'h02, 1'b0);
    push(8'hA5, 1'b0);
    push(8'h5A, 1'b0);
    push(8'h3C, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored", {30'd0, busy, byte_ready}, 32'd3);
    check("busy_start_no_done", {30'd0, done, error}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_flags", {27'd0, byte_ready, cpu_enable, busy, done, error}, 32'd0);
    check("mid_rst_we", 32'(imem_we), 32'd0);
    check("mid_rst_waddr", imem_waddr, 32'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {27'd0, byte_ready, cpu_enable, busy, done, error}, 32'd0);
    check("mid_rst_no_writes", 32'(wr_addr.size() - base_w), 32'd0);

    // Loader still works after the abort
    exp_words = '{32'h2001_0005, 32'h0000_0000};
    run_frame("after_rst", 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
